// File: rtl/forward_hazard_unit_if.sv
// Bundle of decode-stage sources, producer-stage descriptors and hazard results
// exchanged between the pipeline control path and forward_hazard_unit.
// Ports: master = pipeline side (drives sources/producers, reads selects and stall),
//        slave  = hazard unit side (reads sources/producers, drives selects and stall).
interface forward_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 16
);

  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_FWD-1:0]          stg_wr_en;
  logic [NUM_FWD*REG_AW-1:0]   stg_wr_addr;
  logic [NUM_FWD-1:0]          stg_is_load;
  logic                        mem_ready;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall;
  logic [CNT_W-1:0]            stall_count;

  modport master (
    output id_valid,
    output id_src_addr,
    output stg_wr_en,
    output stg_wr_addr,
    output stg_is_load,
    output mem_ready,
    input  fwd_sel,
    input  stall,
    input  stall_count
  );

  modport slave (
    input  id_valid,
    input  id_src_addr,
    input  stg_wr_en,
    input  stg_wr_addr,
    input  stg_is_load,
    input  mem_ready,
    output fwd_sel,
    output stall,
    output stall_count
  );

endinterface

// File: rtl/forward_hazard_unit.sv
// Operand forwarding select and load-use stall generation for the pipelined core.
// Latency: fwd_sel is registered (1 cycle); stall is combinational from the current state/inputs.
// Backpressure: stall holds PC and IF/ID and turns the EX slot into a bubble (fwd_sel forced to 0).
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   hz.slave     id_valid / id_src_addr       decode-stage instruction and its source registers
//                stg_wr_en / stg_wr_addr      per producer stage (0 = EX, 1 = MEM, ...) destination
//                stg_is_load                  producer stage holds a load
//                mem_ready                    data memory has returned load data
//                fwd_sel                      per source: 0 = regfile, k+1 = stage k (registered)
//                stall                        decode stall request
//                stall_count                  saturating count of stalled cycles
module forward_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  forward_hazard_unit_if.slave hz
);

  // Stall sequencer states
  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;

  // The down-counter only has to hold LOAD_LAT-1.
  localparam int            CW        = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(LOAD_LAT - 1);
  localparam bit            LONG_LOAD = (LOAD_LAT > 1);

  logic [NUM_SRC-1:0][NUM_FWD-1:0] match;
  logic [NUM_SRC-1:0][SEL_W-1:0]   sel;
  logic                            ex_hit;
  logic                            lu;

  logic [1:0]                      state;
  logic [1:0]                      state_nxt;
  logic [CW-1:0]                   cnt;
  logic [CW-1:0]                   cnt_nxt;
  logic                            stall_c;

  logic [NUM_SRC*SEL_W-1:0]        fwd_sel_q;
  logic [CNT_W-1:0]                stall_cnt_q;

  // Loads that have already left EX are handled purely by forwarding, so the
  // per-stage load flags beyond stage 0 never influence the outputs.
  logic                            unused_load_flags;
  assign unused_load_flags = ^hz.stg_is_load;

  // ---------------------------------------------------------------------------
  // Producer match matrix. Register 0 is hard-wired and must never be forwarded,
  // so a producer writing r0 is treated as not writing at all.
  // ---------------------------------------------------------------------------
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        match[i][k] = hz.stg_wr_en[k]
                   && (hz.stg_wr_addr[k*REG_AW +: REG_AW] != '0)
                   && (hz.stg_wr_addr[k*REG_AW +: REG_AW] == hz.id_src_addr[i*REG_AW +: REG_AW]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-source select. Scanning from the oldest stage towards EX lets the
  // youngest producer (lowest k) overwrite any older match.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (match[i][k]) begin
          sel[i] = SEL_W'(k + 1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: any valid source depending on a load still in EX. One
  // hazard covers every source that hits the same load.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_hit = ex_hit | match[i][0];
    end
    lu = hz.id_valid && ex_hit && hz.stg_is_load[0];
  end

  // ---------------------------------------------------------------------------
  // Stall sequencer.
  // RUN stalls only for the hazard cycle itself. A load needing more than one
  // cycle, or whose data is not yet back, continues in LOAD_STALL for the
  // remaining fixed latency and then in MEM_WAIT until memory answers.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    case (state)
      RUN: begin
        stall_c = lu;
        if (lu && (LONG_LOAD || !hz.mem_ready)) begin
          state_nxt = LOAD_STALL;
          cnt_nxt   = CNT_INIT;
        end
      end
      LOAD_STALL: begin
        stall_c = 1'b1;
        if (cnt > CW'(1)) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          // Last fixed-latency cycle (cnt == 1), or a single-cycle load that
          // entered here only because memory was late (cnt == 0).
          cnt_nxt   = '0;
          state_nxt = hz.mem_ready ? RUN : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        stall_c = 1'b1;
        if (hz.mem_ready) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered forward select for the instruction entering EX on this edge.
  // A stalled or empty decode slot enters EX as a bubble, which reads nothing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_sel_q <= '0;
    end else if (hz.id_valid && !stall_c) begin
      fwd_sel_q <= sel;
    end else begin
      fwd_sel_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stalled-cycle performance counter, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.fwd_sel     = fwd_sel_q;
  assign hz.stall       = stall_c;
  assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  logic clock;
  logic reset;

  // Shared stimulus; both DUTs see the same inputs.
  logic       id_valid;
  logic [4:0] src0, src1;
  logic [1:0] wr_en;
  logic [4:0] wa0, wa1;
  logic [1:0] is_load;
  logic       mem_ready;

  int total_checks;
  int passed_checks;

  forward_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .SEL_W(3), .CNT_W(16)) if1 ();
  forward_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .SEL_W(3), .CNT_W(16)) if3 ();

  assign if1.id_valid    = id_valid;
  assign if1.id_src_addr = {src1, src0};
  assign if1.stg_wr_en   = wr_en;
  assign if1.stg_wr_addr = {wa1, wa0};
  assign if1.stg_is_load = is_load;
  assign if1.mem_ready   = mem_ready;

  assign if3.id_valid    = id_valid;
  assign if3.id_src_addr = {src1, src0};
  assign if3.stg_wr_en   = wr_en;
  assign if3.stg_wr_addr = {wa1, wa0};
  assign if3.stg_is_load = is_load;
  assign if3.mem_ready   = mem_ready;

  forward_hazard_unit #(
    .REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(1), .SEL_W(3), .CNT_W(16)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .hz    (if1.slave)
  );

  forward_hazard_unit #(
    .REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(3), .SEL_W(3), .CNT_W(16)
  ) dut3 (
    .clock (clock),
    .reset (reset),
    .hz    (if3.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       vld;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] en;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [1:0] ld;
    logic       exp_stall;
    logic [2:0] exp_sel0;
    logic [2:0] exp_sel1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] ld, input logic mr);
    id_valid  = v;
    src0      = s0;
    src1      = s1;
    wr_en     = en;
    wa0       = a0;
    wa1       = a1;
    is_load   = ld;
    mem_ready = mr;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Watchdog: the test sequence is bounded, this only guards against a hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    total_checks  = 0;
    passed_checks = 0;
    reset         = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b1);

    //          vld  s0     s1     en     a0     a1     ld     stall sel0  sel1
    vecs[0]  = '{1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b00, 1'b0, 3'd1, 3'd0}; // EX forward
    vecs[1]  = '{1'b1, 5'd3, 5'd7, 2'b11, 5'd7, 5'd7, 2'b00, 1'b0, 3'd0, 3'd1}; // EX beats MEM
    vecs[2]  = '{1'b1, 5'd3, 5'd7, 2'b10, 5'd7, 5'd7, 2'b00, 1'b0, 3'd0, 3'd2}; // only MEM writes
    vecs[3]  = '{1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 3'd0}; // r0 never forwarded
    vecs[4]  = '{1'b1, 5'd4, 5'd4, 2'b01, 5'd4, 5'd0, 2'b00, 1'b0, 3'd1, 3'd1}; // both srcs same stage
    vecs[5]  = '{1'b1, 5'd6, 5'd8, 2'b11, 5'd8, 5'd6, 2'b00, 1'b0, 3'd2, 3'd1}; // split stages
    vecs[6]  = '{1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 2'b10, 1'b0, 3'd2, 3'd0}; // load in MEM forwards
    vecs[7]  = '{1'b0, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 1'b0, 3'd0, 3'd0}; // invalid slot
    vecs[8]  = '{1'b1, 5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 2'b01, 1'b1, 3'd0, 3'd0}; // load-use, both srcs
    vecs[9]  = '{1'b1, 5'd9, 5'd0, 2'b00, 5'd9, 5'd0, 2'b01, 1'b0, 3'd0, 3'd0}; // load without write
    vecs[10] = '{1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 2'b01, 1'b0, 3'd0, 3'd0}; // load to r0
    vecs[11] = '{1'b1, 5'd3, 5'd2, 2'b11, 5'd5, 5'd6, 2'b00, 1'b0, 3'd0, 3'd0}; // no match

    // Reset state
    do_reset();
    #1;
    chk("reset_fwd_sel1", 32'(if1.fwd_sel), 32'd0);
    chk("reset_stall1", 32'(if1.stall), 32'd0);
    chk("reset_count1", 32'(if1.stall_count), 32'd0);
    chk("reset_fwd_sel3", 32'(if3.fwd_sel), 32'd0);
    chk("reset_count3", 32'(if3.stall_count), 32'd0);

    // Table vectors on the single-cycle-load instance (mem_ready high)
    exp_cnt = 0;
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].vld, vecs[v].s0, vecs[v].s1, vecs[v].en, vecs[v].a0, vecs[v].a1,
            vecs[v].ld, 1'b1);
      #1;
      chk($sformatf("vec%0d_stall", v), 32'(if1.stall), 32'(vecs[v].exp_stall));
      if (vecs[v].exp_stall) exp_cnt++;
      tick();
      chk($sformatf("vec%0d_sel0", v), 32'(if1.fwd_sel[2:0]), 32'(vecs[v].exp_sel0));
      chk($sformatf("vec%0d_sel1", v), 32'(if1.fwd_sel[5:3]), 32'(vecs[v].exp_sel1));
    end
    chk("table_stall_count", 32'(if1.stall_count), 32'(exp_cnt));

    // Load-use with LOAD_LAT = 1: one stall cycle, then forward from MEM
    do_reset();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 1'b1);
    #1;
    chk("lu1_stall", 32'(if1.stall), 32'd1);
    tick();
    chk("lu1_bubble_sel", 32'(if1.fwd_sel), 32'd0);
    drive(1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 2'b10, 1'b1);
    #1;
    chk("lu1_stall_drop", 32'(if1.stall), 32'd0);
    tick();
    chk("lu1_sel_mem", 32'(if1.fwd_sel[2:0]), 32'd2);
    chk("lu1_count", 32'(if1.stall_count), 32'd1);

    // LOAD_LAT = 3 with memory ready: three stall cycles
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 1'b1);
      else        drive(1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 2'b10, 1'b1);
      #1;
      chk($sformatf("lat3_ready_stall_c%0d", c), 32'(if3.stall), (c < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("lat3_ready_count", 32'(if3.stall_count), 32'd3);

    // LOAD_LAT = 3 with mem_ready low two extra cycles: five stall cycles
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 1'b0);
      else        drive(1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 2'b10, (c >= 4) ? 1'b1 : 1'b0);
      #1;
      chk($sformatf("lat3_wait_stall_c%0d", c), 32'(if3.stall), (c < 5) ? 32'd1 : 32'd0);
      if (c == 4) chk("lat3_wait_bubble_sel", 32'(if3.fwd_sel), 32'd0);
      if (c == 5) chk("lat3_wait_count", 32'(if3.stall_count), 32'd5);
      tick();
    end
    chk("lat3_wait_sel_mem", 32'(if3.fwd_sel[2:0]), 32'd2);

    // Reset while in LOAD_STALL
    do_reset();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 1'b1);
    tick();
    drive(1'b1, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 2'b10, 1'b1);
    #1;
    chk("midrst_pre_stall", 32'(if3.stall), 32'd1);
    chk("midrst_pre_count", 32'(if3.stall_count), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(if3.stall), 32'd0);
    chk("midrst_fwd_sel", 32'(if3.fwd_sel), 32'd0);
    chk("midrst_count", 32'(if3.stall_count), 32'd0);

    // Counter saturation: hold a load-use hazard past 65535 stalled cycles
    do_reset();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 2'b01, 1'b1);
    repeat (65540) tick();
    chk("sat_stall", 32'(if1.stall), 32'd1);
    chk("sat_count", 32'(if1.stall_count), 32'h0000FFFF);
    tick();
    chk("sat_count_hold", 32'(if1.stall_count), 32'h0000FFFF);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
